// File: rtl/riscv_mem_pkg.sv
// Shared memory-subsystem definitions for the RISC-V core, its data memory
// and the data-memory arbiter.
package riscv_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 14;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic {
    ARB_SHARED = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store unit and the
// host port: round-robin in SHARED, host-only in LOCKED, with stall counters.
module dmem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_lock,
  output logic              locked,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  cpu_stall_cnt,
  output logic [CNT_W-1:0]  host_stall_cnt
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       cpu_rvalid_q, host_rvalid_q;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q <= ARB_SHARED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_SHARED: if (host_lock)  state_d = ARB_LOCKED;
      ARB_LOCKED: if (!host_lock) state_d = ARB_SHARED;
      default:    state_d = ARB_SHARED;
    endcase
  end

  // Grants follow the registered state, so the cycle that first sees
  // host_lock still arbitrates round-robin.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ARB_SHARED: begin
          if (cpu_req && host_req) begin
            cpu_gnt  = (last_q == PORT_HOST);
            host_gnt = (last_q == PORT_CPU);
          end else begin
            cpu_gnt  = cpu_req;
            host_gnt = host_req;
          end
        end
        ARB_LOCKED: host_gnt = host_req;
        default: ;
      endcase
    end
  end

  // Holding last at host while locked hands the CPU the first contended slot.
  always_comb begin
    last_d = last_q;
    if (cpu_gnt) begin
      last_d = PORT_CPU;
    end
    if (host_gnt || (state_q == ARB_LOCKED)) begin
      last_d = PORT_HOST;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      last_q        <= PORT_HOST;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      last_q        <= last_d;
      cpu_rvalid_q  <= cpu_gnt && !cpu_we;
      host_rvalid_q <= host_gnt && !host_we;
    end
  end

  always_comb begin
    mem_en    = cpu_gnt || host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  assign cpu_rvalid  = cpu_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign cpu_rdata   = cpu_rvalid_q  ? mem_rdata : '0;
  assign host_rdata  = host_rvalid_q ? mem_rdata : '0;
  assign locked      = (state_q == ARB_LOCKED);

  sat_counter #(.CNT_W(CNT_W)) u_cpu_stall (
    .clk   (CLOCK_50),
    .rst   (rst),
    .inc   (cpu_req && !cpu_gnt),
    .count (cpu_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_host_stall (
    .clk   (CLOCK_50),
    .rst   (rst),
    .inc   (host_req && !host_gnt),
    .count (host_stall_cnt)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic, all checked against a rule-level reference model.
module tb_dmem_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [13:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
  logic [13:0] host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic [31:0] mem_rdata = '0;

  logic        cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, locked;
  logic [31:0] cpu_rdata, host_rdata, mem_wdata;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] cpu_stall_cnt, host_stall_cnt;

  logic        s_cpu_gnt, s_cpu_rvalid, s_host_gnt, s_host_rvalid, s_locked;
  logic [31:0] s_cpu_rdata, s_host_rdata, s_mem_wdata;
  logic        s_mem_en, s_mem_we;
  logic [13:0] s_mem_addr;
  logic [3:0]  s_cpu_stall_cnt, s_host_stall_cnt;

  always #5 CLOCK_50 = ~CLOCK_50;

  dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .CNT_W(32)) dut (
    .CLOCK_50(CLOCK_50), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_lock(host_lock), .locked(locked),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .cpu_stall_cnt(cpu_stall_cnt), .host_stall_cnt(host_stall_cnt)
  );

  // Narrow-counter copy on the same stimulus, used for saturation checks.
  dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .CNT_W(4)) dut_small (
    .CLOCK_50(CLOCK_50), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(s_cpu_gnt), .cpu_rvalid(s_cpu_rvalid), .cpu_rdata(s_cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(s_host_gnt), .host_rvalid(s_host_rvalid), .host_rdata(s_host_rdata),
    .host_lock(host_lock), .locked(s_locked),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(mem_rdata),
    .cpu_stall_cnt(s_cpu_stall_cnt), .host_stall_cnt(s_host_stall_cnt)
  );

  function automatic logic [31:0] init_word(input logic [13:0] a);
    return (a == 14'd5) ? 32'd7 : ({18'd0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous-read memory driven by the DUT's command outputs.
  logic [31:0] envmem [logic [13:0]];
  always @(posedge CLOCK_50) begin
    if (mem_en && !mem_we)
      mem_rdata <= envmem.exists(mem_addr) ? envmem[mem_addr] : init_word(mem_addr);
    if (mem_en && mem_we)
      envmem[mem_addr] = mem_wdata;
  end

  // Reference model state.
  logic [31:0] shadow [logic [13:0]];
  bit          m_locked, m_last, m_crv, m_hrv, e_gc, e_gh;
  logic [31:0] m_crd, m_hrd;
  longint      m_ccnt, m_hcnt, m_scnt;
  bit          obs_gc, obs_gh;
  int          errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] shadow_rd(input logic [13:0] a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  function automatic longint sat_inc(input longint v, input longint maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic cycle();
    @(negedge CLOCK_50);
    // Expected grants from the arbitration rules.
    e_gc = 1'b0; e_gh = 1'b0;
    if (!rst) begin
      if (m_locked) e_gh = host_req;
      else if (cpu_req && host_req) begin e_gc = m_last; e_gh = !m_last; end
      else begin e_gc = cpu_req; e_gh = host_req; end
    end
    obs_gc = cpu_gnt; obs_gh = host_gnt;
    chk("cpu_gnt", {63'd0, cpu_gnt}, {63'd0, e_gc});
    chk("host_gnt", {63'd0, host_gnt}, {63'd0, e_gh});
    chk("mem_en", {63'd0, mem_en}, {63'd0, e_gc | e_gh});
    chk("mem_we", {63'd0, mem_we}, {63'd0, (e_gc & cpu_we) | (e_gh & host_we)});
    if (e_gc | e_gh)
      chk("mem_addr", {50'd0, mem_addr}, {50'd0, e_gh ? host_addr : cpu_addr});
    if ((e_gc & cpu_we) | (e_gh & host_we))
      chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, e_gh ? host_wdata : cpu_wdata});
    chk("cpu_rvalid", {63'd0, cpu_rvalid}, {63'd0, m_crv});
    chk("host_rvalid", {63'd0, host_rvalid}, {63'd0, m_hrv});
    chk("cpu_rdata", {32'd0, cpu_rdata}, {32'd0, m_crv ? m_crd : 32'd0});
    chk("host_rdata", {32'd0, host_rdata}, {32'd0, m_hrv ? m_hrd : 32'd0});
    chk("locked", {63'd0, locked}, {63'd0, m_locked});
    chk("cpu_stall", {32'd0, cpu_stall_cnt}, m_ccnt);
    chk("host_stall", {32'd0, host_stall_cnt}, m_hcnt);
    chk("small_stall", {60'd0, s_cpu_stall_cnt}, m_scnt);
    // Advance the model to the next cycle.
    if (rst) begin
      m_locked = 0; m_last = 1; m_crv = 0; m_hrv = 0;
      m_ccnt = 0; m_hcnt = 0; m_scnt = 0;
    end else begin
      if (cpu_req && !e_gc) begin
        m_ccnt = sat_inc(m_ccnt, 64'hFFFF_FFFF);
        m_scnt = sat_inc(m_scnt, 15);
      end
      if (host_req && !e_gh) m_hcnt = sat_inc(m_hcnt, 64'hFFFF_FFFF);
      m_crv = e_gc && !cpu_we;
      m_hrv = e_gh && !host_we;
      if (m_crv) m_crd = shadow_rd(cpu_addr);
      if (m_hrv) m_hrd = shadow_rd(host_addr);
      if (e_gc && cpu_we) shadow[cpu_addr] = cpu_wdata;
      if (e_gh && host_we) shadow[host_addr] = host_wdata;
      if (e_gc) m_last = 0;
      if (e_gh || m_locked) m_last = 1;
      m_locked = host_lock;
    end
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle_reset();
    rst = 1; cpu_req = 0; host_req = 0; host_lock = 0;
    cycle();
    rst = 0;
  endtask

  initial begin
    int seq, pulses, cpu_in_lock, hw;
    m_last = 1; m_crd = '0; m_hrd = '0;

    // Solo CPU read of address 5.
    idle_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'd5;
    cycle();
    cpu_req = 0;
    chk("t1_rvalid", {63'd0, cpu_rvalid}, 64'd1);
    chk("t1_rdata", {32'd0, cpu_rdata}, 64'd7);
    chk("t1_host_rdata", {32'd0, host_rdata}, 64'd0);
    cycle();

    // Contention right after reset: CPU, host, CPU, host.
    idle_reset();
    cpu_req = 1; cpu_we = 0; host_req = 1; host_we = 0;
    seq = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_addr = 14'(10 + i); host_addr = 14'(20 + i);
      cycle();
      seq = (seq << 1) | int'(obs_gc);
    end
    chk("t2_grant_seq", 64'(seq), 64'b1010);
    chk("t2_cpu_stall", {32'd0, cpu_stall_cnt}, 64'd2);
    chk("t2_host_stall", {32'd0, host_stall_cnt}, 64'd2);
    cpu_req = 0; host_req = 0;
    cycle();

    // Host lock bulk load while the CPU keeps requesting.
    idle_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'd7;
    host_lock = 1; host_req = 1; host_we = 1;
    host_addr = 14'd5000; host_wdata = 32'hA000_0000;
    cycle();  // transition cycle still arbitrates round-robin
    pulses = 0; cpu_in_lock = 0; hw = 0;
    for (int i = 0; i < 20 && hw < 10; i++) begin
      cycle();
      if (obs_gc) cpu_in_lock++;
      if (obs_gh) begin
        hw++; pulses++;
        host_addr = 14'(5000 + hw); host_wdata = 32'hA000_0000 + 32'(hw);
      end
    end
    chk("t3_cpu_gnt_locked", 64'(cpu_in_lock), 64'd0);
    chk("t3_we_pulses", 64'(pulses), 64'd10);
    chk("t3_stall_ge10", {63'd0, cpu_stall_cnt >= 32'd10}, 64'd1);
    host_lock = 0; host_req = 0;
    cycle();
    host_req = 1; host_we = 0; host_addr = 14'd5003;
    cycle();
    chk("t3_cpu_first", {63'd0, obs_gc}, 64'd1);
    cpu_req = 0;
    cycle();
    host_req = 0;
    cycle();

    // Reset while a host read is in flight.
    idle_reset();
    host_req = 1; host_we = 0; host_addr = 14'd9;
    cycle();
    host_req = 0; rst = 1;
    cycle();
    rst = 0;
    chk("t4_host_rvalid", {63'd0, host_rvalid}, 64'd0);
    chk("t4_cpu_cnt", {32'd0, cpu_stall_cnt}, 64'd0);
    chk("t4_host_cnt", {32'd0, host_stall_cnt}, 64'd0);
    chk("t4_locked", {63'd0, locked}, 64'd0);
    cycle();

    // Saturation of the narrow counter.
    idle_reset();
    host_lock = 1; host_req = 1; host_we = 1; host_addr = 14'd300;
    cpu_req = 1; cpu_we = 0; cpu_addr = 14'd1;
    cycle();  // CPU wins the transition cycle
    for (int i = 0; i < 20; i++) cycle();
    chk("t5_sat", {60'd0, s_cpu_stall_cnt}, 64'd15);
    chk("t5_wide", {32'd0, cpu_stall_cnt}, 64'd20);
    cpu_req = 0; host_req = 0; host_lock = 0;
    cycle();

    // CPU write then host read of the same address.
    idle_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 14'd100; cpu_wdata = 32'hFFFF_FFF6;
    cycle();
    cpu_req = 0; host_req = 1; host_we = 0; host_addr = 14'd100;
    cycle();
    host_req = 0;
    chk("t6_rvalid", {63'd0, host_rvalid}, 64'd1);
    chk("t6_rdata", {32'd0, host_rdata}, 64'h0000_0000_FFFF_FFF6);
    cycle();

    // Random traffic; pending requests stay stable until granted.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 15) == 0) host_lock = !host_lock;
      if (!cpu_req || obs_gc) begin
        cpu_req = ($urandom_range(0, 99) < 60);
        cpu_we = $urandom_range(0, 1) == 1;
        cpu_addr = 14'($urandom_range(0, 31));
        cpu_wdata = $urandom;
      end
      if (!host_req || obs_gh) begin
        host_req = ($urandom_range(0, 99) < 60);
        host_we = $urandom_range(0, 1) == 1;
        host_addr = ($urandom_range(0, 7) == 0) ? 14'($urandom_range(5000, 5015))
                                                : 14'($urandom_range(0, 31));
        host_wdata = $urandom;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the CPU load/store unit and a host port. The host port preloads the matrix operands and reads back the product matrix. It sits between `RISCVCPU`'s data-memory interface and the `D_Memory` instance. It provides round-robin grant, an exclusive host lock for bulk transfers, aligned read-data return, and per-port stall counters for CPI analysis.

## Interface
Parameters:
- `ADDR_W`, 14: word-address width. It covers M*N + N*N2 + M*N2 words.
- `DATA_W`, 32: data word width.
- `CNT_W`, 32: stall counter width.

Ports:
- `CLOCK_50` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `cpu_req` in 1: CPU access request. Held until granted.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in `ADDR_W`: word address.
- `cpu_wdata` in `DATA_W`: write data.
- `cpu_gnt` out 1: access accepted this cycle.
- `cpu_rvalid` out 1: read data valid. Asserted exactly one cycle after a granted read.
- `cpu_rdata` out `DATA_W`: read data. Valid when `cpu_rvalid` is 1, 0 otherwise.
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_gnt`, `host_rvalid`, `host_rdata`: same semantics as the CPU signals, for the host port.
- `host_lock` in 1: host requests exclusive ownership of the memory.
- `locked` out 1: the arbiter is in LOCKED state.
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out `ADDR_W`, `mem_wdata` out `DATA_W`: memory command. Combinational from the granted port.
- `mem_rdata` in `DATA_W`: synchronous-read memory output, one-cycle latency.
- `cpu_stall_cnt` out `CNT_W`: cycles with `cpu_req` high and `cpu_gnt` low. Saturating.
- `host_stall_cnt` out `CNT_W`: cycles with `host_req` high and `host_gnt` low. Saturating.

## Operation
State machine with two states, SHARED and LOCKED.
- **SHARED → LOCKED:** on the first cycle where `host_lock` = 1. In the transition cycle the arbiter still performs SHARED arbitration.
- **LOCKED → SHARED:** on the first cycle where `host_lock` = 0.

Arbitration in SHARED:
- A register `last` records the most recently granted port (0 = CPU, 1 = host).
- Only one port requests: that port is granted.
- Both ports request: the port ≠ `last` is granted.
- `last` updates on every grant.
- No request: no grant, `mem_en` = 0, `last` holds.

Arbitration in LOCKED:
- Only the host can be granted. `cpu_gnt` = 0 regardless of `cpu_req`, and the CPU stall counter keeps counting.
- `last` is set to 1 (host) on exit, so the CPU wins the first contended cycle afterwards.

Grant and data path:
- At most one grant per cycle. `cpu_gnt` & `host_gnt` = 0 always.
- Grant is combinational from `req`, state and `last`. There is no grant without the matching `req`.
- A granted write completes in the grant cycle. There is no write response.
- A granted read sets that port's rvalid register for the next cycle. `mem_rdata` is routed only to the port whose rvalid is 1. The other port's rdata is 0.
- Back-to-back reads: a new grant in the same cycle as an rvalid is legal, so there is full throughput of one access per cycle.

Stall counters:
- Each counter increments by 1 per stalled cycle.
- Each counter saturates at all-ones and does not wrap.

Reset (`rst` = 1 at a clock edge), effective from the next cycle:
- State = SHARED, `last` = 1.
- `cpu_rvalid` = `host_rvalid` = 0.
- Both stall counters = 0.
- `locked` = 0.
- During the reset cycle all grants and `mem_en` are forced to 0.
- An in-flight read is dropped: its rvalid is not asserted after reset.

## Timing
- Grant latency: 0 cycles when uncontended.
- Worst-case wait in SHARED: 1 cycle, because round-robin limits it to one access by the other port.
- Read latency: grant at cycle t, then rvalid and rdata at cycle t+1.
- Write: `mem_we` pulses for the grant cycle only.
- `locked` is registered. It rises the cycle after `host_lock` is first sampled 1.
- Requester rule: `req`, `we`, `addr` and `wdata` must stay stable from assertion until the cycle `gnt` = 1.

## Structure
- Shared package `riscv_mem_pkg`:
  - state encoding `ARB_SHARED` = 1'b0, `ARB_LOCKED` = 1'b1;
  - port IDs `PORT_CPU` = 0, `PORT_HOST` = 1;
  - default `ADDR_W` and `DATA_W`, shared with `D_Memory` and `RISCVCPU`.
- One sub-module, `sat_counter` (parameter `CNT_W`, inputs `inc` and `rst`), instantiated twice for the stall counters.
- The grant mux and rdata steering stay inline.

## Test plan
1. **Solo CPU read.** Host idle, `mem_rdata` returns 32'h0000_0007 for address 5.
   - CPU read at address 5 → `cpu_gnt` = 1 at cycle t.
   - `mem_addr` = 5, `mem_en` = 1, `mem_we` = 0 at t.
   - `cpu_rvalid` = 1 and `cpu_rdata` = 7 at t+1.
   - `host_rdata` = 0 and both stall counters stay 0.
2. **Contention after reset.** Both ports request reads continuously for 4 cycles.
   - Grants go CPU, host, CPU, host.
   - Each rvalid lands exactly one cycle after its grant.
   - `cpu_stall_cnt` = 2 and `host_stall_cnt` = 2.
3. **Host lock bulk load.** `host_lock` = 1 and `host_req` held for 10 writes to addresses 5000–5009 while `cpu_req` = 1.
   - `cpu_gnt` never asserts.
   - 10 consecutive `mem_we` pulses.
   - `cpu_stall_cnt` counts 10 or more.
   - After `host_lock` drops, the CPU is granted first on the next contended cycle.
4. **Reset mid-read.**
   - Host read granted at cycle t, `rst` = 1 at t+1 → `host_rvalid` stays 0 after reset.
   - Counters read 0, `locked` = 0.
5. **Counter saturation.** Use `CNT_W` = 4 and stall the CPU for 20 cycles → `cpu_stall_cnt` holds at 15.
6. **Mixed write/read to the same address.**
   - CPU writes 32'hFFFF_FFF6 (-10) to address 100, then the host reads address 100 next cycle.
   - `host_rdata` = 32'hFFFF_FFF6, with write-then-read ordering preserved.
